// File: rtl/sha256_core.sv
// sha256_core: SHA-256 compression engine that chains its digest across blocks and runs ROUNDS_PER_CYCLE rounds per clock.
// Defining SHA256_CORE_SHA224_EN adds the mode_224 input, which selects the SHA-224 IV and truncates the output.
module sha256_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic [511:0] in_data,
`ifdef SHA256_CORE_SHA224_EN
    input  logic         mode_224,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest
);

    // state | meaning
    // IDLE  | waiting for a block, in_ready high
    // ROUND | ROUNDS_PER_CYCLE compression rounds per clock
    // FINAL | add working variables into the chain, register the digest
    // OUT   | digest held until out_ready
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_OUT} state_t;

    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [5:0] LAST_ROUND = 6'(64 - R);

    if (R != 1 && R != 2 && R != 4) begin : g_bad_rounds
        $error("sha256_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

`ifdef SHA256_CORE_SHA224_EN
    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t       r_state;
    logic [31:0]  r_h [8];
    logic [31:0]  r_v [8];
    logic [31:0]  r_w [16];
    logic [5:0]   r_round;
    logic         r_out_valid;
    logic [255:0] r_digest;
`ifdef SHA256_CORE_SHA224_EN
    logic         r_mode_224;
`endif

    logic [31:0]  w_ext [16 + R];
    logic [31:0]  w_st [R + 1][8];
    logic [31:0]  w_t1 [R];
    logic [31:0]  w_t2 [R];
    logic [31:0]  w_start [8];
    logic [31:0]  w_sum [8];
    logic [255:0] w_digest;

    // Window extended by R words so one cycle can consume R schedule words and shift by R.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = r_w[i];
        end
        for (int i = 16; i < 16 + R; i++) begin
            w_ext[i] = small_s1(w_ext[i-2]) + w_ext[i-7] + small_s0(w_ext[i-15]) + w_ext[i-16];
        end
    end

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            w_st[0][j] = r_v[j];
        end
        for (int k = 0; k < R; k++) begin
            w_t1[k] = w_st[k][7] + big_s1(w_st[k][4]) + ch(w_st[k][4], w_st[k][5], w_st[k][6])
                    + K[r_round + 6'(k)] + w_ext[k];
            w_t2[k] = big_s0(w_st[k][0]) + maj(w_st[k][0], w_st[k][1], w_st[k][2]);
            w_st[k+1][0] = w_t1[k] + w_t2[k];
            w_st[k+1][1] = w_st[k][0];
            w_st[k+1][2] = w_st[k][1];
            w_st[k+1][3] = w_st[k][2];
            w_st[k+1][4] = w_st[k][3] + w_t1[k];
            w_st[k+1][5] = w_st[k][4];
            w_st[k+1][6] = w_st[k][5];
            w_st[k+1][7] = w_st[k][6];
        end
    end

    always_comb begin
        w_digest = '0;
        for (int j = 0; j < 8; j++) begin
            w_start[j] = in_first ? IV256[j] : r_h[j];
`ifdef SHA256_CORE_SHA224_EN
            if (in_first && mode_224) begin
                w_start[j] = IV224[j];
            end
`endif
            w_sum[j] = r_h[j] + r_v[j];
            w_digest[32*j +: 32] = w_sum[j];
        end
`ifdef SHA256_CORE_SHA224_EN
        if (r_mode_224) begin
            w_digest[255:224] = '0;
        end
`endif
    end

    // r_h is reloaded with the start state on accept, so FINAL simply adds the working variables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_digest    <= '0;
            r_round     <= '0;
            for (int j = 0; j < 8; j++) begin
                r_h[j] <= IV256[j];
                r_v[j] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
`ifdef SHA256_CORE_SHA224_EN
            r_mode_224  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= in_data[32*i +: 32];
                        end
                        for (int j = 0; j < 8; j++) begin
                            r_v[j] <= w_start[j];
                            r_h[j] <= w_start[j];
                        end
                        r_round <= '0;
`ifdef SHA256_CORE_SHA224_EN
                        r_mode_224 <= mode_224;
`endif
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    for (int j = 0; j < 8; j++) begin
                        r_v[j] <= w_st[R][j];
                    end
                    for (int i = 0; i < 16; i++) begin
                        r_w[i] <= w_ext[i + R];
                    end
                    r_round <= r_round + 6'(R);
                    if (r_round == LAST_ROUND) begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    for (int j = 0; j < 8; j++) begin
                        r_h[j] <= w_sum[j];
                    end
                    r_digest    <= w_digest;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_out_valid;
    assign out_digest = r_digest;

endmodule

// File: tb/tb_sha256_core.sv
// Bench for sha256_core: known vectors, chaining, backpressure, mid-block reset and random blocks vs a reference model.
// Three instances cover ROUNDS_PER_CYCLE = 1, 2 and 4; the SHA-224 case is built when SHA256_CORE_SHA224_EN is defined.
module tb_sha256_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_a   [3];
    logic         in_ready_a   [3];
    logic         in_first_a   [3];
    logic [511:0] in_data_a    [3];
    logic         out_valid_a  [3];
    logic         out_ready_a  [3];
    logic [255:0] out_digest_a [3];
`ifdef SHA256_CORE_SHA224_EN
    logic         mode_224_a   [3];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sha256_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid_a[g]),
            .in_ready   (in_ready_a[g]),
            .in_first   (in_first_a[g]),
            .in_data    (in_data_a[g]),
`ifdef SHA256_CORE_SHA224_EN
            .mode_224   (mode_224_a[g]),
`endif
            .out_valid  (out_valid_a[g]),
            .out_ready  (out_ready_a[g]),
            .out_digest (out_digest_a[g])
        );
    end

    localparam logic [255:0] IV      = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [255:0] ABC_DIG = 256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    localparam logic [255:0] TWO_DIG = 256'h19db06c1_f6ecedd4_64ff2167_a33ce459_0c3e6039_e5c02693_d20638b8_248d6a61;
`ifdef SHA256_CORE_SHA224_EN
    localparam logic [255:0] IV224   = 256'hbefa4fa4_64f98fa7_68581511_ffc00b31_f70e5939_3070dd17_367cd507_c1059ed8;
    localparam logic [255:0] ABC_224 = 256'h00000000_e36c9da7_bda0b3f7_2aadbce4_bda255b3_8642a477_3405d822_23097d22;
`endif

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain FIPS 180-4 compression: full 64-word schedule, one round per loop step.
    function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int j = 0; j < 8; j++) v[j] = h[32*j +: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) r[32*j +: 32] = h[32*j +: 32] + v[j];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns with out_valid seen (or budget expired) and in_valid low.
    task automatic send_block(input int idx, input logic first, input logic [511:0] data,
                              output logic [255:0] dig, output int lat);
        int n;
        n = 0;
        while (!in_ready_a[idx] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_bit("in_ready_before_send", in_ready_a[idx], 1'b1);
        in_valid_a[idx] = 1'b1;
        in_first_a[idx] = first;
        in_data_a[idx]  = data;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[idx] = 1'b0;
        lat = 0;
        while (!out_valid_a[idx] && lat < 200) begin
            in_valid_a[idx] = 1'($urandom);
            in_first_a[idx] = 1'($urandom);
            in_data_a[idx]  = rand512();
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid_a[idx] = 1'b0;
        dig = out_digest_a[idx];
    endtask

    task automatic release_out(input int idx);
        in_valid_a[idx]  = 1'b0;
        out_ready_a[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_a[idx] = 1'b0;
        check_bit("release_out_valid", out_valid_a[idx], 1'b0);
        check_bit("release_in_ready", in_ready_a[idx], 1'b1);
    endtask

    typedef struct {
        logic         first;
        logic [511:0] data;
        logic [255:0] exp;
    } vec_t;

    vec_t         vecs [3];
    logic [255:0] m_chain [3];
    logic [511:0] abc_blk;
    logic [511:0] two_b1;
    logic [511:0] two_b2;
    logic [255:0] dig;
    logic [255:0] held;
    logic [255:0] exp_d;
    logic [511:0] rblk;
    logic         rfirst;
    int           lat;
    int           ridx;
    int           seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            in_first_a[i]  = 1'b0;
            in_data_a[i]   = '0;
            out_ready_a[i] = 1'b0;
`ifdef SHA256_CORE_SHA224_EN
            mode_224_a[i]  = 1'b0;
`endif
        end

        abc_blk = '0;
        abc_blk[31:0]    = 32'h61626380;
        abc_blk[511:480] = 32'h00000018;
        two_b1 = '0;
        for (int i = 0; i < 14; i++) begin
            for (int b = 0; b < 4; b++) two_b1[32*i + 8*(3-b) +: 8] = 8'(8'h61 + i + b);
        end
        two_b1[479:448] = 32'h80000000;
        two_b2 = '0;
        two_b2[511:480] = 32'h000001c0;

        vecs[0] = '{first: 1'b1, data: abc_blk, exp: ABC_DIG};
        vecs[1] = '{first: 1'b1, data: two_b1,  exp: ref_compress(IV, two_b1)};
        vecs[2] = '{first: 1'b0, data: two_b2,  exp: TWO_DIG};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_bit("reset_out_valid", out_valid_a[i], 1'b0);
            check("reset_out_digest", out_digest_a[i], '0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_bit("in_ready_after_reset", in_ready_a[i], 1'b1);
        @(negedge clk);

        for (int idx = 0; idx < 3; idx++) begin
            for (int v = 0; v < 3; v++) begin
                send_block(idx, vecs[v].first, vecs[v].data, dig, lat);
                check("table_digest", dig, vecs[v].exp);
                check_int("table_latency", lat, (64 >> idx) + 1);
                release_out(idx);
            end
            m_chain[idx] = TWO_DIG;
        end

        send_block(0, 1'b1, abc_blk, dig, lat);
        check("bp_digest", dig, ABC_DIG);
        held = dig;
        for (int c = 0; c < 10; c++) begin
            in_valid_a[0] = 1'b1;
            in_first_a[0] = 1'b1;
            in_data_a[0]  = rand512();
            @(posedge clk);
            @(negedge clk);
            check_bit("bp_out_valid", out_valid_a[0], 1'b1);
            check("bp_digest_stable", out_digest_a[0], held);
            check_bit("bp_in_ready", in_ready_a[0], 1'b0);
        end
        release_out(0);
        m_chain[0] = ABC_DIG;

        for (int it = 0; it < 12; it++) begin
            ridx   = int'($urandom_range(2, 0));
            rfirst = ($urandom_range(2, 0) == 0);
            rblk   = rand512();
            exp_d  = ref_compress(rfirst ? IV : m_chain[ridx], rblk);
            send_block(ridx, rfirst, rblk, dig, lat);
            check("rand_digest", dig, exp_d);
            check_int("rand_latency", lat, (64 >> ridx) + 1);
            release_out(ridx);
            m_chain[ridx] = exp_d;
        end

        in_valid_a[0] = 1'b1;
        in_first_a[0] = 1'b1;
        in_data_a[0]  = abc_blk;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_bit("midrst_out_valid", out_valid_a[0], 1'b0);
        check_bit("midrst_in_ready", in_ready_a[0], 1'b1);
        check("midrst_digest", out_digest_a[0], '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) m_chain[i] = IV;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (out_valid_a[0]) seen++;
        end
        check_int("midrst_no_spurious_valid", seen, 0);
        send_block(0, 1'b0, abc_blk, dig, lat);
        check("midrst_abc_digest", dig, ABC_DIG);
        check_int("midrst_latency", lat, 65);
        release_out(0);

`ifdef SHA256_CORE_SHA224_EN
        for (int idx = 0; idx < 3; idx++) begin
            mode_224_a[idx] = 1'b1;
            send_block(idx, 1'b1, abc_blk, dig, lat);
            mode_224_a[idx] = 1'b0;
            exp_d = ref_compress(IV224, abc_blk);
            exp_d[255:224] = '0;
            check("sha224_digest", dig, ABC_224);
            check("sha224_model", dig, exp_d);
            check_int("sha224_latency", lat, (64 >> idx) + 1);
            release_out(idx);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
